// File: rtl/regfile_read_scoreboard.sv
// Register file read side: 16 registers, two bypassed read ports, one write port,
// and a per-register pending-write scoreboard that drives decode-stage stalls.
module regfile_read_scoreboard #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            SrcReg1,
    input  logic [3:0]            SrcReg2,
    output logic [DATA_WIDTH-1:0] SrcData1,
    output logic [DATA_WIDTH-1:0] SrcData2,
    input  logic [3:0]            DstReg,
    input  logic                  WriteReg,
    input  logic [DATA_WIDTH-1:0] DstData,
    input  logic [3:0]            IssueReg,
    input  logic                  IssueValid,
    output logic                  Busy1,
    output logic                  Busy2,
    output logic                  Stall
);

    localparam int NREGS = 16;

    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic [CNT_WIDTH-1:0]  cnt  [NREGS];
    logic [NREGS-1:0]      writeDec;
    logic [NREGS-1:0]      issueDec;

    // One-hot decoders; bit 0 is masked so R0 never stores data or counts.
    always_comb begin
        writeDec           = '0;
        issueDec           = '0;
        writeDec[DstReg]   = WriteReg;
        issueDec[IssueReg] = IssueValid;
        writeDec[0]        = 1'b0;
        issueDec[0]        = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (writeDec[r]) begin
                    regs[r] <= DstData;
                end
                // Issue and writeback on the same edge cancel out.
                if (issueDec[r] && !writeDec[r] && cnt[r] != '1) begin
                    cnt[r] <= cnt[r] + CNT_WIDTH'(1);
                end else if (writeDec[r] && !issueDec[r] && cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_WIDTH'(1);
                end
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] readData(input logic [3:0] src);
        if (src == 4'd0) begin
            return '0;
        end
        if (WriteReg && DstReg == src) begin
            return DstData;
        end
        return regs[src];
    endfunction

    // A single outstanding write is satisfied by a writeback in the same cycle.
    function automatic logic readBusy(input logic [3:0] src);
        logic [CNT_WIDTH-1:0] c;
        c = cnt[src];
        if (src == 4'd0) begin
            return 1'b0;
        end
        if (c > CNT_WIDTH'(1)) begin
            return 1'b1;
        end
        return (c == CNT_WIDTH'(1)) && !(WriteReg && DstReg == src);
    endfunction

    always_comb begin
        SrcData1 = readData(SrcReg1);
        SrcData2 = readData(SrcReg2);
        Busy1    = readBusy(SrcReg1);
        Busy2    = readBusy(SrcReg2);
        Stall    = Busy1 | Busy2;
    end

endmodule

// File: tb/tb_regfile_read_scoreboard.sv
// Bench for regfile_read_scoreboard: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_regfile_read_scoreboard;

    localparam int DW     = 16;
    localparam int CW     = 2;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    SrcReg1, SrcReg2, DstReg, IssueReg;
    logic [DW-1:0] SrcData1, SrcData2, DstData;
    logic          WriteReg, IssueValid;
    logic          Busy1, Busy2, Stall;

    int tests  = 0;
    int failed = 0;

    int mreg [16];
    int mcnt [16];
    bit modelValid = 1'b0;

    regfile_read_scoreboard #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
        .SrcData1(SrcData1), .SrcData2(SrcData2),
        .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
        .IssueReg(IssueReg), .IssueValid(IssueValid),
        .Busy1(Busy1), .Busy2(Busy2), .Stall(Stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: state as plain integers, outputs from the read/busy rules.
    function automatic int expData(input int s);
        if (s == 0) return 0;
        if (WriteReg && int'(DstReg) == s) return int'(DstData);
        return mreg[s];
    endfunction

    function automatic bit expBusy(input int s);
        if (s == 0) return 1'b0;
        return (mcnt[s] >= 2) || (mcnt[s] == 1 && !(WriteReg && int'(DstReg) == s));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 16; r++) begin
                mreg[r] = 0;
                mcnt[r] = 0;
            end
            modelValid = 1'b1;
        end else begin
            for (int r = 1; r < 16; r++) begin
                bit inc, dec;
                inc = IssueValid && int'(IssueReg) == r;
                dec = WriteReg && int'(DstReg) == r;
                if (inc && !dec && mcnt[r] < CNTMAX) mcnt[r] = mcnt[r] + 1;
                if (dec && !inc && mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
            end
            if (WriteReg && DstReg != 4'd0) mreg[DstReg] = int'(DstData);
        end
    end

    always @(negedge clk) begin
        if (modelValid && rst_n) begin
            bit b1, b2;
            b1 = expBusy(int'(SrcReg1));
            b2 = expBusy(int'(SrcReg2));
            chk("model SrcData1", 32'(SrcData1), 32'(expData(int'(SrcReg1))));
            chk("model SrcData2", 32'(SrcData2), 32'(expData(int'(SrcReg2))));
            chk("model Busy1", 32'(Busy1), 32'(b1));
            chk("model Busy2", 32'(Busy2), 32'(b2));
            chk("model Stall", 32'(Stall), 32'(b1 | b2));
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
        WriteReg   = 1'b0;
        IssueValid = 1'b0;
        rst_n      = 1'b1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; WriteReg = 1'b0; IssueValid = 1'b0;
        SrcReg1 = '0; SrcReg2 = '0; DstReg = '0; IssueReg = '0; DstData = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state across every register id.
        for (int s = 0; s < 16; s++) begin
            nextCycle();
            SrcReg1 = 4'(s); SrcReg2 = 4'(15 - s);
            settle();
            chk("reset SrcData1", 32'(SrcData1), 32'h0);
            chk("reset SrcData2", 32'(SrcData2), 32'h0);
            chk("reset Stall", 32'({Busy1, Busy2, Stall}), 32'h0);
        end

        // Bypass then storage read.
        nextCycle();
        SrcReg1 = 4'd5; DstReg = 4'd5; DstData = 16'hBEEF; WriteReg = 1'b1;
        settle();
        chk("bypass R5", 32'(SrcData1), 32'hBEEF);
        nextCycle();
        settle();
        chk("stored R5", 32'(SrcData1), 32'hBEEF);

        // R0 ignores writes and issues.
        nextCycle();
        SrcReg1 = 4'd0; DstReg = 4'd0; DstData = 16'h1234; WriteReg = 1'b1;
        IssueReg = 4'd0; IssueValid = 1'b1;
        settle();
        chk("R0 data", 32'(SrcData1), 32'h0);
        chk("R0 busy", 32'(Busy1), 32'h0);
        nextCycle();
        settle();
        chk("R0 data next", 32'(SrcData1), 32'h0);
        chk("R0 busy next", 32'(Busy1), 32'h0);

        // Two outstanding writes to R3.
        nextCycle();
        SrcReg2 = 4'd3; IssueReg = 4'd3; IssueValid = 1'b1;
        settle();
        chk("R3 issue cycle busy", 32'(Busy2), 32'h0);
        nextCycle();
        IssueValid = 1'b1;
        settle();
        chk("R3 cnt1 busy", 32'(Busy2), 32'h1);
        nextCycle();
        settle();
        chk("R3 cnt2 stall", 32'({Busy2, Stall}), 32'h3);
        nextCycle();
        DstReg = 4'd3; DstData = 16'h3333; WriteReg = 1'b1;
        settle();
        chk("R3 first wb busy", 32'(Busy2), 32'h1);
        nextCycle();
        DstReg = 4'd3; DstData = 16'h4444; WriteReg = 1'b1;
        settle();
        chk("R3 last wb busy", 32'(Busy2), 32'h0);
        chk("R3 last wb data", 32'(SrcData2), 32'h4444);

        // Simultaneous issue and writeback keep the count at 1.
        nextCycle();
        SrcReg1 = 4'd7; IssueReg = 4'd7; IssueValid = 1'b1;
        nextCycle();
        IssueReg = 4'd7; IssueValid = 1'b1;
        DstReg = 4'd7; DstData = 16'h00AA; WriteReg = 1'b1;
        settle();
        chk("R7 same-edge busy", 32'(Busy1), 32'h0);
        nextCycle();
        settle();
        chk("R7 after busy", 32'(Busy1), 32'h1);
        chk("R7 after data", 32'(SrcData1), 32'h00AA);
        nextCycle();
        DstReg = 4'd7; DstData = 16'h00AA; WriteReg = 1'b1;

        // Saturation and underflow on R9.
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            SrcReg1 = 4'd9; IssueReg = 4'd9; IssueValid = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            DstReg = 4'd9; DstData = 16'(16'h9000 + i); WriteReg = 1'b1;
            settle();
            chk("R9 drain busy", 32'(Busy1), (i == 2) ? 32'h0 : 32'h1);
        end
        nextCycle();
        DstReg = 4'd9; DstData = 16'h9999; WriteReg = 1'b1;
        settle();
        chk("R9 underflow bypass", 32'(SrcData1), 32'h9999);
        nextCycle();
        settle();
        chk("R9 underflow stored", 32'(SrcData1), 32'h9999);
        chk("R9 underflow busy", 32'(Busy1), 32'h0);

        // Reset mid-operation overrides write and issue.
        nextCycle();
        IssueReg = 4'd9; IssueValid = 1'b1;
        nextCycle();
        IssueReg = 4'd9; IssueValid = 1'b1;
        nextCycle();
        rst_n = 1'b0; DstReg = 4'd2; DstData = 16'h5A5A; WriteReg = 1'b1;
        IssueReg = 4'd9; IssueValid = 1'b1;
        nextCycle();
        SrcReg1 = 4'd9; SrcReg2 = 4'd5;
        settle();
        chk("post-reset R9 busy", 32'({Busy1, Stall}), 32'h0);
        chk("post-reset R9 data", 32'(SrcData1), 32'h0);
        chk("post-reset R5 data", 32'(SrcData2), 32'h0);
        SrcReg2 = 4'd2;
        #1;
        chk("post-reset R2 data", 32'(SrcData2), 32'h0);

        // Randomized traffic; small register window to create hazards.
        for (int n = 0; n < 3000; n++) begin
            nextCycle();
            SrcReg1    = 4'($urandom_range(0, 7));
            SrcReg2    = 4'($urandom_range(0, 7));
            DstReg     = 4'($urandom_range(0, 7));
            IssueReg   = 4'($urandom_range(0, 7));
            DstData    = 16'($urandom);
            WriteReg   = ($urandom_range(0, 99) < 45);
            IssueValid = ($urandom_range(0, 99) < 50);
            rst_n      = ($urandom_range(0, 199) != 0);
        end
        nextCycle();
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
